// File: rtl/data_mem_lsu.sv
// ---------------------------------------------------------------------------
// data_mem_lsu
//
// Byte-addressable data memory with an integrated load/store alignment unit
// for the single-cycle RV32I core. Stores merge byte/half/word data into the
// addressed word on the rising edge; loads are combinational and return
// sign- or zero-extended data to the writeback mux.
//
// Parameters:
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 4)
//   ADDR_W      : word-index width, derived from DEPTH_WORDS
//
// Ports:
//   clk         : core clock, all state updates on the rising edge
//   rst_n       : synchronous active-low reset, clears the whole array
//   mem_write   : store enable
//   mem_read    : load enable
//   funct3      : RV32I access size / sign encoding
//   addr        : byte address from the ALU
//   write_data  : right-aligned store data (rs2)
//   read_data   : extended load result (0 when not a valid load)
//   misaligned  : current access violates its natural alignment
// ---------------------------------------------------------------------------
module data_mem_lsu #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        misaligned
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [31:0]       mem_q [DEPTH_WORDS];
    logic [31:0]       mem_d [DEPTH_WORDS];

    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       wr_word;
    logic              wr_size_ok;
    logic              store_en;
    logic              half_access;
    logic              word_access;

    // Address bits above the word index are deliberately ignored so that
    // addresses wrap modulo the memory size.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    assign word_idx = addr[ADDR_W+1:2];
    assign rd_word  = mem_q[word_idx];

    assign half_access = (funct3 == F3_H) || (funct3 == F3_HU);
    assign word_access = (funct3 == F3_W);

    assign misaligned = (mem_read | mem_write)
                      & ((half_access & addr[0]) | (word_access & (|addr[1:0])));

    // Lane extraction for loads; the half lane is chosen by addr[1] only
    // because odd half addresses are already flagged misaligned.
    assign rd_byte = rd_word[{addr[1:0], 3'b000} +: 8];
    assign rd_half = rd_word[{addr[1], 4'b0000} +: 16];

    // Load path: extension by funct3, forced to zero for non-loads,
    // misaligned accesses and while reset is asserted.
    always_comb begin
        read_data = 32'h0;
        if (mem_read && !misaligned && rst_n) begin
            case (funct3)
                F3_B:    read_data = {{24{rd_byte[7]}}, rd_byte};
                F3_H:    read_data = {{16{rd_half[15]}}, rd_half};
                F3_W:    read_data = rd_word;
                F3_BU:   read_data = {24'h0, rd_byte};
                F3_HU:   read_data = {16'h0, rd_half};
                default: read_data = 32'h0;
            endcase
        end
    end

    // Store path: merge the right-aligned store data into the current word
    // so that untouched lanes keep their contents.
    always_comb begin
        wr_word    = rd_word;
        wr_size_ok = 1'b1;
        case (funct3)
            F3_B:    wr_word[{addr[1:0], 3'b000} +: 8]  = write_data[7:0];
            F3_H:    wr_word[{addr[1], 4'b0000} +: 16]  = write_data[15:0];
            F3_W:    wr_word                            = write_data;
            default: wr_size_ok                         = 1'b0;
        endcase
    end

    // Misaligned stores are dropped completely rather than partially written.
    assign store_en = mem_write & wr_size_ok & ~misaligned;

    always_comb begin
        mem_d = mem_q;
        if (store_en) begin
            mem_d[word_idx] = wr_word;
        end
    end

    // Reset clears every word in one edge and wins over a same-cycle store.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '{default: 32'h0};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// ---------------------------------------------------------------------------
// tb_data_mem_lsu
//
// Table-driven bench for data_mem_lsu. Each vector drives one cycle of
// inputs after the falling edge; the expected read_data/misaligned pair is
// pushed to a scoreboard queue and popped/compared before the next rising
// edge, so loads see pre-edge contents and stores commit on that edge.
// ---------------------------------------------------------------------------
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_write;
    logic        mem_read;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        misaligned;

    always #5 clk = ~clk;

    data_mem_lsu #(.DEPTH_WORDS(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .funct3     (funct3),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .misaligned (misaligned)
    );

    typedef struct {
        string       name;
        logic        rst_n;
        logic        we;
        logic        re;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(string name, logic r, logic we, logic re,
                                logic [2:0] f3, logic [31:0] a,
                                logic [31:0] w, logic [31:0] e, logic m);
        vec_t v;
        v.name = name; v.rst_n = r; v.we = we; v.re = re; v.f3 = f3;
        v.addr = a; v.wdata = w; v.exp_rd = e; v.exp_mis = m;
        return v;
    endfunction

    // Drive one cycle of inputs mid-cycle and record what the DUT must show.
    task automatic apply_stimulus(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst_n      = v.rst_n;
        mem_write  = v.we;
        mem_read   = v.re;
        funct3     = v.f3;
        addr       = v.addr;
        write_data = v.wdata;
        #1;
        e.name    = v.name;
        e.exp_rd  = v.exp_rd;
        e.exp_mis = v.exp_mis;
        sb_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare against the settled outputs.
    task automatic check_output();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty: got no expectation, required one");
            return;
        end
        e = sb_q.pop_front();
        checks++;
        if (read_data !== e.exp_rd) begin
            errors++;
            $display("[TB] FAIL %s read_data: got %h required %h",
                     e.name, read_data, e.exp_rd);
        end
        checks++;
        if (misaligned !== e.exp_mis) begin
            errors++;
            $display("[TB] FAIL %s misaligned: got %b required %b",
                     e.name, misaligned, e.exp_mis);
        end
    endtask

    task automatic run_vec(input vec_t v);
        apply_stimulus(v);
        check_output();
    endtask

    initial begin
        rst_n      = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        write_data = 32'h0;

        //              name            rst we re f3      addr        wdata         exp_rd        mis
        vecs.push_back(mk("rst_lw0",     0, 0, 1, 3'b010, 32'h000, 32'h0,        32'h0,        0));
        vecs.push_back(mk("lw_0x000",    1, 0, 1, 3'b010, 32'h000, 32'h0,        32'h0,        0));
        vecs.push_back(mk("lw_0x3fc",    1, 0, 1, 3'b010, 32'h3FC, 32'h0,        32'h0,        0));
        vecs.push_back(mk("lw_0x200",    1, 0, 1, 3'b010, 32'h200, 32'h0,        32'h0,        0));
        vecs.push_back(mk("sw_0x10",     1, 1, 0, 3'b010, 32'h010, 32'h80807F01, 32'h0,        0));
        vecs.push_back(mk("lb_0x10",     1, 0, 1, 3'b000, 32'h010, 32'h0,        32'h00000001, 0));
        vecs.push_back(mk("lb_0x11",     1, 0, 1, 3'b000, 32'h011, 32'h0,        32'h0000007F, 0));
        vecs.push_back(mk("lb_0x13",     1, 0, 1, 3'b000, 32'h013, 32'h0,        32'hFFFFFF80, 0));
        vecs.push_back(mk("lbu_0x13",    1, 0, 1, 3'b100, 32'h013, 32'h0,        32'h00000080, 0));
        vecs.push_back(mk("lbu_0x12",    1, 0, 1, 3'b100, 32'h012, 32'h0,        32'h00000080, 0));
        vecs.push_back(mk("lh_0x10",     1, 0, 1, 3'b001, 32'h010, 32'h0,        32'h00007F01, 0));
        vecs.push_back(mk("lh_0x12",     1, 0, 1, 3'b001, 32'h012, 32'h0,        32'hFFFF8080, 0));
        vecs.push_back(mk("lhu_0x12",    1, 0, 1, 3'b101, 32'h012, 32'h0,        32'h00008080, 0));
        vecs.push_back(mk("lw_0x10",     1, 0, 1, 3'b010, 32'h010, 32'h0,        32'h80807F01, 0));
        vecs.push_back(mk("ld_f3_011",   1, 0, 1, 3'b011, 32'h010, 32'h0,        32'h0,        0));
        vecs.push_back(mk("noread_0x10", 1, 0, 0, 3'b010, 32'h010, 32'h0,        32'h0,        0));
        vecs.push_back(mk("sw_0x20",     1, 1, 0, 3'b010, 32'h020, 32'hAABBCCDD, 32'h0,        0));
        vecs.push_back(mk("sb_0x22",     1, 1, 0, 3'b000, 32'h022, 32'hFFFFFF11, 32'h0,        0));
        vecs.push_back(mk("sh_0x20",     1, 1, 0, 3'b001, 32'h020, 32'hFFFF3344, 32'h0,        0));
        vecs.push_back(mk("lw_0x20",     1, 0, 1, 3'b010, 32'h020, 32'h0,        32'hAA113344, 0));
        vecs.push_back(mk("sh_mis_0x31", 1, 1, 0, 3'b001, 32'h031, 32'hFFFFFFFF, 32'h0,        1));
        vecs.push_back(mk("sw_mis_0x42", 1, 1, 0, 3'b010, 32'h042, 32'hFFFFFFFF, 32'h0,        1));
        vecs.push_back(mk("lw_0x30",     1, 0, 1, 3'b010, 32'h030, 32'h0,        32'h0,        0));
        vecs.push_back(mk("lw_0x40",     1, 0, 1, 3'b010, 32'h040, 32'h0,        32'h0,        0));
        vecs.push_back(mk("lh_mis_0x31", 1, 0, 1, 3'b001, 32'h031, 32'h0,        32'h0,        1));
        vecs.push_back(mk("lw_mis_0x12", 1, 0, 1, 3'b010, 32'h012, 32'h0,        32'h0,        1));
        vecs.push_back(mk("lhu_mis_0x13",1, 0, 1, 3'b101, 32'h013, 32'h0,        32'h0,        1));
        vecs.push_back(mk("idle_no_mis", 1, 0, 0, 3'b001, 32'h031, 32'h0,        32'h0,        0));
        vecs.push_back(mk("sw_0x404",    1, 1, 0, 3'b010, 32'h404, 32'h12345678, 32'h0,        0));
        vecs.push_back(mk("lw_wrap_0x4", 1, 0, 1, 3'b010, 32'h004, 32'h0,        32'h12345678, 0));
        vecs.push_back(mk("st_f3_011",   1, 1, 0, 3'b011, 32'h024, 32'hFFFFFFFF, 32'h0,        0));
        vecs.push_back(mk("lw_0x24_a",   1, 0, 1, 3'b010, 32'h024, 32'h0,        32'h0,        0));
        vecs.push_back(mk("sb_0x27",     1, 1, 0, 3'b000, 32'h027, 32'h000000A5, 32'h0,        0));
        vecs.push_back(mk("lb_0x27",     1, 0, 1, 3'b000, 32'h027, 32'h0,        32'hFFFFFFA5, 0));
        vecs.push_back(mk("lw_0x24_b",   1, 0, 1, 3'b010, 32'h024, 32'h0,        32'hA5000000, 0));
        vecs.push_back(mk("sh_0x26",     1, 1, 0, 3'b001, 32'h026, 32'h0000BEEF, 32'h0,        0));
        vecs.push_back(mk("lw_0x24_c",   1, 0, 1, 3'b010, 32'h024, 32'h0,        32'hBEEF0000, 0));

        $display("[TB] running %0d table vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // Same-cycle load and store: old value before the edge, new after.
        run_vec(mk("sw_0x60",        1, 1, 0, 3'b010, 32'h060, 32'h0BADF00D, 32'h0,        0));
        run_vec(mk("rw_0x60_old",    1, 1, 1, 3'b010, 32'h060, 32'hCAFEBABE, 32'h0BADF00D, 0));
        run_vec(mk("lw_0x60_new",    1, 0, 1, 3'b010, 32'h060, 32'h0,        32'hCAFEBABE, 0));

        // Mid-program reset with a concurrent store: store is discarded,
        // read_data is held at zero during reset, and the array is cleared.
        run_vec(mk("rst_sw_0x50",    0, 1, 1, 3'b010, 32'h050, 32'hDEADBEEF, 32'h0,        0));
        run_vec(mk("lw_0x50_after",  1, 0, 1, 3'b010, 32'h050, 32'h0,        32'h0,        0));
        run_vec(mk("lw_0x60_after",  1, 0, 1, 3'b010, 32'h060, 32'h0,        32'h0,        0));
        run_vec(mk("lw_0x20_after",  1, 0, 1, 3'b010, 32'h020, 32'h0,        32'h0,        0));

        @(negedge clk);
        mem_write = 1'b0;
        mem_read  = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
